// File: rtl/pipibibs_cen_pkg.sv
// ---------------------------------------------------------------------------
// pipibibs_cen_pkg
// Shared definitions for the CLK96 clock-enable monitors.
//   cen_state_e   : monitor FSM state encoding (IDLE / MEASURE / STALLED)
//   CEN_GAP_*     : expected CLK96 cycle gaps of the derived enables
//   gap_in_range  : inclusive range test used by the per-gap legality check
// ---------------------------------------------------------------------------
package pipibibs_cen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALLED = 2'd2
  } cen_state_e;

  // CLK96 (94.5 MHz) divided down to the enable rates used by the cores
  localparam int unsigned CEN_GAP_13M5   = 7;   // 13.5    MHz
  localparam int unsigned CEN_GAP_6M75   = 14;  // 6.75    MHz
  localparam int unsigned CEN_GAP_3M375  = 28;  // 3.375   MHz
  localparam int unsigned CEN_GAP_1M6875 = 56;  // 1.6875  MHz

  function automatic logic gap_in_range(input int unsigned gap,
                                        input int unsigned lo,
                                        input int unsigned hi);
    return (gap >= lo) && (gap <= hi);
  endfunction

endpackage

// File: rtl/pipibibs_gap_counter.sv
// ---------------------------------------------------------------------------
// pipibibs_gap_counter
// Counts CLK96 cycles since the last CEN-high cycle. Loads 1 on CEN so that
// the value seen in the next CEN cycle equals the gap (back-to-back = 1).
// Saturates at all-ones; flags when the count has reached TIMEOUT.
// Ports:
//   i_clk        clock (CLK96)
//   i_rst        synchronous active-high reset, clears the count to 0
//   i_cen        enable under test
//   o_cnt        current gap count (registered)
//   o_timeout_c  combinational: o_cnt >= TIMEOUT
// ---------------------------------------------------------------------------
module pipibibs_gap_counter #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cen,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_timeout_c
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [CNT_W-1:0] r_cnt;

  // load-on-CEN, saturating increment otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_cen) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != CNT_SAT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt       = r_cnt;
  assign o_timeout_c = (r_cnt >= CNT_W'(TIMEOUT));

endmodule

// File: rtl/pipibibs_cen_monitor.sv
// ---------------------------------------------------------------------------
// pipibibs_cen_monitor
// Consumer-side checker for a fractional clock enable. Measures the CLK96
// gap between successive CEN pulses, accumulates 2**WIN_LOG2 gaps per window
// and reports total/min/max, lock status and sticky error flags.
// Ports:
//   CLK96      94.5 MHz clock, sole clock
//   RESET      synchronous active-high reset
//   CEN        enable under test
//   CLR        clears ERR_GAP / ERR_STALL (a same-cycle set wins)
//   WIN_TOTAL  sum of gaps in the last completed window
//   WIN_MIN    smallest gap in the last completed window
//   WIN_MAX    largest gap in the last completed window
//   WIN_VALID  one-cycle pulse when WIN_* update
//   LOCKED     last full window entirely within [EXP_MIN, EXP_MAX]
//   ERR_GAP    sticky: a gap fell outside [EXP_MIN, EXP_MAX]
//   ERR_STALL  sticky: TIMEOUT cycles elapsed with no CEN while measuring
// ---------------------------------------------------------------------------
module pipibibs_cen_monitor
  import pipibibs_cen_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WIN_LOG2 = 4,
  parameter int unsigned EXP_MIN  = CEN_GAP_13M5,
  parameter int unsigned EXP_MAX  = CEN_GAP_13M5,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic                      CLK96,
  input  logic                      RESET,
  input  logic                      CEN,
  input  logic                      CLR,
  output logic [CNT_W+WIN_LOG2-1:0] WIN_TOTAL,
  output logic [CNT_W-1:0]          WIN_MIN,
  output logic [CNT_W-1:0]          WIN_MAX,
  output logic                      WIN_VALID,
  output logic                      LOCKED,
  output logic                      ERR_GAP,
  output logic                      ERR_STALL
);

  localparam int unsigned TOT_W = CNT_W + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] IDX_LAST = '1;

  cen_state_e          r_state;

  logic [TOT_W-1:0]    r_acc_total;
  logic [CNT_W-1:0]    r_acc_min;
  logic [CNT_W-1:0]    r_acc_max;
  logic                r_acc_bad;
  logic [WIN_LOG2-1:0] r_idx;

  logic [TOT_W-1:0]    r_win_total;
  logic [CNT_W-1:0]    r_win_min;
  logic [CNT_W-1:0]    r_win_max;
  logic                r_win_valid;
  logic                r_locked;
  logic                r_err_gap;
  logic                r_err_stall;

  logic [CNT_W-1:0]    w_gap;
  logic                w_timeout;
  logic                w_start;
  logic                w_record;
  logic                w_close;
  logic                w_gap_bad;
  logic                w_gap_set;
  logic                w_stall_set;
  logic                w_acc_clr;
  logic [TOT_W-1:0]    w_tot_next;
  logic [CNT_W-1:0]    w_min_next;
  logic [CNT_W-1:0]    w_max_next;
  logic                w_bad_next;

  pipibibs_gap_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_gap_counter (
    .i_clk       (CLK96),
    .i_rst       (RESET),
    .i_cen       (CEN),
    .o_cnt       (w_gap),
    .o_timeout_c (w_timeout)
  );

  // event decode for the current cycle
  assign w_start     = (r_state != ST_MEASURE) && CEN;
  assign w_record    = (r_state == ST_MEASURE) && CEN;
  assign w_close     = w_record && (r_idx == IDX_LAST);
  assign w_stall_set = (r_state == ST_MEASURE) && !CEN && w_timeout;
  assign w_gap_bad   = !gap_in_range(32'(w_gap), EXP_MIN, EXP_MAX);
  assign w_gap_set   = w_record && w_gap_bad;

  // a window restarts on first CEN, on its own closing CEN, and on stall
  assign w_acc_clr   = w_start || w_close || w_stall_set;

  // accumulator values including the gap being recorded this cycle
  assign w_tot_next  = r_acc_total + TOT_W'(w_gap);
  assign w_min_next  = (w_gap < r_acc_min) ? w_gap : r_acc_min;
  assign w_max_next  = (w_gap > r_acc_max) ? w_gap : r_acc_max;
  assign w_bad_next  = r_acc_bad || w_gap_bad;

  // FSM, lock status and sticky error flags
  always_ff @(posedge CLK96) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_locked    <= 1'b0;
      r_err_gap   <= 1'b0;
      r_err_stall <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_STALLED: begin
          if (CEN) begin
            r_state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_stall_set) begin
            r_state <= ST_STALLED;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_close) begin
        r_locked <= !w_bad_next;
      end else if (w_gap_set || w_stall_set) begin
        r_locked <= 1'b0;
      end

      // set takes priority over a coincident clear
      if (w_gap_set) begin
        r_err_gap <= 1'b1;
      end else if (CLR) begin
        r_err_gap <= 1'b0;
      end

      if (w_stall_set) begin
        r_err_stall <= 1'b1;
      end else if (CLR) begin
        r_err_stall <= 1'b0;
      end
    end
  end

  // per-window accumulators and gap index
  always_ff @(posedge CLK96) begin
    if (RESET || w_acc_clr) begin
      r_acc_total <= '0;
      r_acc_min   <= '1;
      r_acc_max   <= '0;
      r_acc_bad   <= 1'b0;
      r_idx       <= '0;
    end else if (w_record) begin
      r_acc_total <= w_tot_next;
      r_acc_min   <= w_min_next;
      r_acc_max   <= w_max_next;
      r_acc_bad   <= w_bad_next;
      r_idx       <= r_idx + WIN_LOG2'(1);
    end
  end

  // window report registers, held until the next window closes
  always_ff @(posedge CLK96) begin
    if (RESET) begin
      r_win_total <= '0;
      r_win_min   <= '0;
      r_win_max   <= '0;
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= w_close;
      if (w_close) begin
        r_win_total <= w_tot_next;
        r_win_min   <= w_min_next;
        r_win_max   <= w_max_next;
      end
    end
  end

  assign WIN_TOTAL = r_win_total;
  assign WIN_MIN   = r_win_min;
  assign WIN_MAX   = r_win_max;
  assign WIN_VALID = r_win_valid;
  assign LOCKED    = r_locked;
  assign ERR_GAP   = r_err_gap;
  assign ERR_STALL = r_err_stall;

endmodule

// File: tb/tb_pipibibs_cen_monitor.sv
// ---------------------------------------------------------------------------
// tb_pipibibs_cen_monitor
// Self-checking bench: directed scenarios plus randomized CEN gaps, compared
// against a window/gap model built from CEN timestamps. A second instance
// with a legal gap of 1 covers the CEN-held-high case.
// ---------------------------------------------------------------------------
module tb_pipibibs_cen_monitor;

  localparam int unsigned L_EXP     = 7;
  localparam int unsigned L_TIMEOUT = 32;
  localparam int unsigned L_WIN     = 16;
  localparam int unsigned L_SAT     = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic cen = 1'b0;
  logic cen1 = 1'b0;
  logic clr = 1'b0;

  logic [11:0] win_total, win_total1;
  logic [7:0]  win_min, win_min1, win_max, win_max1;
  logic        win_valid, win_valid1, locked, locked1;
  logic        err_gap, err_gap1, err_stall, err_stall1;

  pipibibs_cen_monitor dut (
    .CLK96(clk), .RESET(rst), .CEN(cen), .CLR(clr),
    .WIN_TOTAL(win_total), .WIN_MIN(win_min), .WIN_MAX(win_max),
    .WIN_VALID(win_valid), .LOCKED(locked),
    .ERR_GAP(err_gap), .ERR_STALL(err_stall)
  );

  pipibibs_cen_monitor #(.EXP_MIN(1), .EXP_MAX(1)) dut1 (
    .CLK96(clk), .RESET(rst), .CEN(cen1), .CLR(clr),
    .WIN_TOTAL(win_total1), .WIN_MIN(win_min1), .WIN_MAX(win_max1),
    .WIN_VALID(win_valid1), .LOCKED(locked1),
    .ERR_GAP(err_gap1), .ERR_STALL(err_stall1)
  );

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;
  int unsigned tcyc   = 0;

  // reference model: gaps from CEN timestamps, windows as a queue of gaps
  logic [11:0] exp_total = '0;
  logic [7:0]  exp_min = '0, exp_max = '0;
  logic        exp_valid = 1'b0, exp_locked = 1'b0;
  logic        exp_err_gap = 1'b0, exp_err_stall = 1'b0;

  int unsigned m_cyc = 0;
  int unsigned m_last = 0;
  bit          m_active = 1'b0;
  int unsigned m_gaps[$];
  int unsigned m_g, m_s, m_mn, m_mx;
  bit          m_ok, m_gset, m_sset;

  always @(posedge clk) begin
    m_cyc++;
    if (rst) begin
      exp_total = '0; exp_min = '0; exp_max = '0;
      exp_valid = 1'b0; exp_locked = 1'b0;
      exp_err_gap = 1'b0; exp_err_stall = 1'b0;
      m_active = 1'b0;
      m_gaps.delete();
    end else begin
      m_gset = 1'b0;
      m_sset = 1'b0;
      exp_valid = 1'b0;
      if (cen) begin
        if (m_active) begin
          m_g = m_cyc - m_last;
          if (m_g > L_SAT) m_g = L_SAT;
          m_gaps.push_back(m_g);
          if (m_g != L_EXP) begin
            m_gset = 1'b1;
            exp_locked = 1'b0;
          end
          if (m_gaps.size() == L_WIN) begin
            m_s = 0; m_mn = L_SAT; m_mx = 0; m_ok = 1'b1;
            foreach (m_gaps[i]) begin
              m_s += m_gaps[i];
              if (m_gaps[i] < m_mn) m_mn = m_gaps[i];
              if (m_gaps[i] > m_mx) m_mx = m_gaps[i];
              if (m_gaps[i] != L_EXP) m_ok = 1'b0;
            end
            exp_total  = 12'(m_s);
            exp_min    = 8'(m_mn);
            exp_max    = 8'(m_mx);
            exp_valid  = 1'b1;
            exp_locked = m_ok;
            m_gaps.delete();
          end
        end else begin
          m_active = 1'b1;
          m_gaps.delete();
        end
        m_last = m_cyc;
      end else if (m_active && ((m_cyc - m_last) >= L_TIMEOUT)) begin
        m_active = 1'b0;
        m_sset = 1'b1;
        exp_locked = 1'b0;
        m_gaps.delete();
      end
      if (m_gset) exp_err_gap = 1'b1;
      else if (clr) exp_err_gap = 1'b0;
      if (m_sset) exp_err_stall = 1'b1;
      else if (clr) exp_err_stall = 1'b0;
    end
  end

  logic [31:0] w_obs, w_exp;
  assign w_obs = {win_total, win_min, win_max, win_valid, locked, err_gap, err_stall};
  assign w_exp = {exp_total, exp_min, exp_max, exp_valid, exp_locked, exp_err_gap, exp_err_stall};

  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; cen = 1'b0; cen1 = 1'b0; clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b0; cen1 = 1'b0; clr = 1'b0;
    tick();
    tick();
    n_run++;
    if (w_obs !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 00000000", w_obs);
    end
    n_run++;
    if ({win_total1, win_min1, win_max1, win_valid1, locked1, err_gap1, err_stall1} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_dut1 got %h exp 00000000",
               {win_total1, win_min1, win_max1, win_valid1, locked1, err_gap1, err_stall1});
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int unsigned v1 = 0;
    do_reset();
    for (int p = 1; p <= 40; p++) begin
      for (int c = 1; c <= 7; c++) begin
        cen = (c == 7);
        tick();
        n_run++;
        if (w_obs !== w_exp) begin
          n_fail++;
          $display("FAIL t1_model cyc=%0d got %h exp %h", tcyc, w_obs, w_exp);
        end
      end
      if (p == 17) begin
        v1 = tcyc;
        n_run++;
        if (!(win_valid === 1'b1 && win_total === 12'd112 && win_min === 8'd7 &&
              win_max === 8'd7 && locked === 1'b1 && err_gap === 1'b0 && err_stall === 1'b0)) begin
          n_fail++;
          $display("FAIL t1_win1 got v=%0b tot=%0d min=%0d max=%0d lk=%0b eg=%0b es=%0b exp 1/112/7/7/1/0/0",
                   win_valid, win_total, win_min, win_max, locked, err_gap, err_stall);
        end
      end
      if (p == 33) begin
        n_run++;
        if (win_valid !== 1'b1 || (tcyc - v1) != 112) begin
          n_fail++;
          $display("FAIL t1_period got valid=%0b dist=%0d exp valid=1 dist=112", win_valid, tcyc - v1);
        end
      end
    end
    cen = 1'b0;
  endtask

  task automatic test_bad_gap();
    int unsigned g;
    do_reset();
    for (int p = 1; p <= 49; p++) begin
      g = (p == 20) ? 8 : 7;
      for (int c = 1; c <= int'(g); c++) begin
        cen = (c == int'(g));
        tick();
        n_run++;
        if (w_obs !== w_exp) begin
          n_fail++;
          $display("FAIL t2_model cyc=%0d got %h exp %h", tcyc, w_obs, w_exp);
        end
      end
      if (p == 20) begin
        n_run++;
        if (err_gap !== 1'b1 || locked !== 1'b0) begin
          n_fail++;
          $display("FAIL t2_flag got err_gap=%0b locked=%0b exp 1/0", err_gap, locked);
        end
      end
      if (p == 33) begin
        n_run++;
        if (!(win_valid === 1'b1 && win_total === 12'd113 && win_max === 8'd8 &&
              win_min === 8'd7 && locked === 1'b0)) begin
          n_fail++;
          $display("FAIL t2_win2 got v=%0b tot=%0d min=%0d max=%0d lk=%0b exp 1/113/7/8/0",
                   win_valid, win_total, win_min, win_max, locked);
        end
      end
      if (p == 49) begin
        n_run++;
        if (!(win_valid === 1'b1 && win_total === 12'd112 && locked === 1'b1 && err_gap === 1'b1)) begin
          n_fail++;
          $display("FAIL t2_win3 got v=%0b tot=%0d lk=%0b eg=%0b exp 1/112/1/1",
                   win_valid, win_total, locked, err_gap);
        end
      end
    end
    cen = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    for (int p = 1; p <= 20; p++) begin
      for (int c = 1; c <= 7; c++) begin
        cen = (c == 7);
        tick();
        n_run++;
        if (w_obs !== w_exp) begin
          n_fail++;
          $display("FAIL t3_model cyc=%0d got %h exp %h", tcyc, w_obs, w_exp);
        end
      end
    end
    cen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_run++;
      if (w_obs !== w_exp || win_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL t3_gap_model k=%0d got %h exp %h", k, w_obs, w_exp);
      end
      if (k == 31) begin
        n_run++;
        if (err_stall !== 1'b0 || locked !== 1'b1) begin
          n_fail++;
          $display("FAIL t3_early got err_stall=%0b locked=%0b exp 0/1", err_stall, locked);
        end
      end
      if (k == 32) begin
        n_run++;
        if (err_stall !== 1'b1 || locked !== 1'b0 || win_total !== 12'd112) begin
          n_fail++;
          $display("FAIL t3_stall got err_stall=%0b locked=%0b tot=%0d exp 1/0/112",
                   err_stall, locked, win_total);
        end
      end
    end
    for (int q = 1; q <= 17; q++) begin
      for (int c = 1; c <= 7; c++) begin
        cen = (c == 7);
        tick();
        n_run++;
        if (w_obs !== w_exp) begin
          n_fail++;
          $display("FAIL t3_resume_model cyc=%0d got %h exp %h", tcyc, w_obs, w_exp);
        end
      end
      if (q == 16) begin
        n_run++;
        if (win_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL t3_early_valid got %0b exp 0", win_valid);
        end
      end
      if (q == 17) begin
        n_run++;
        if (win_valid !== 1'b1 || win_total !== 12'd112 || locked !== 1'b1) begin
          n_fail++;
          $display("FAIL t3_resume got v=%0b tot=%0d lk=%0b exp 1/112/1", win_valid, win_total, locked);
        end
      end
    end
    cen = 1'b0;
  endtask

  task automatic test_clr();
    do_reset();
    for (int p = 1; p <= 4; p++) begin
      for (int c = 1; c <= ((p == 4) ? 8 : 7); c++) begin
        cen = (c == ((p == 4) ? 8 : 7));
        clr = (p == 4) && (c == 8);
        tick();
        n_run++;
        if (w_obs !== w_exp) begin
          n_fail++;
          $display("FAIL t4_model cyc=%0d got %h exp %h", tcyc, w_obs, w_exp);
        end
      end
    end
    n_run++;
    if (err_gap !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_set_wins got err_gap=%0b exp 1", err_gap);
    end
    cen = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_run++;
    if (err_gap !== 1'b0 || w_obs !== w_exp) begin
      n_fail++;
      $display("FAIL t4_clear got err_gap=%0b obs %h exp 0 / %h", err_gap, w_obs, w_exp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int p = 1; p <= 22; p++) begin
      for (int c = 1; c <= 7; c++) begin
        cen = (c == 7);
        tick();
      end
    end
    n_run++;
    if (win_total !== 12'd112 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_pre got tot=%0d lk=%0b exp 112/1", win_total, locked);
    end
    cen = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_run++;
    if (w_obs !== 32'h0) begin
      n_fail++;
      $display("FAIL t5_reset got %h exp 00000000", w_obs);
    end
    for (int p = 1; p <= 17; p++) begin
      for (int c = 1; c <= 7; c++) begin
        cen = (c == 7);
        tick();
        n_run++;
        if (w_obs !== w_exp || (p < 17 && win_valid !== 1'b0)) begin
          n_fail++;
          $display("FAIL t5_model p=%0d got %h exp %h", p, w_obs, w_exp);
        end
      end
    end
    n_run++;
    if (win_valid !== 1'b1 || win_total !== 12'd112) begin
      n_fail++;
      $display("FAIL t5_first_win got v=%0b tot=%0d exp 1/112", win_valid, win_total);
    end
    cen = 1'b0;
  endtask

  task automatic test_cen_high();
    logic expv;
    do_reset();
    cen = 1'b1;
    cen1 = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      tick();
      expv = (k >= 17) && (((k - 17) % 16) == 0);
      n_run++;
      if (win_valid1 !== expv) begin
        n_fail++;
        $display("FAIL t6_valid k=%0d got %0b exp %0b", k, win_valid1, expv);
      end
      if (expv) begin
        n_run++;
        if (win_total1 !== 12'd16 || win_min1 !== 8'd1 || win_max1 !== 8'd1 ||
            locked1 !== 1'b1 || err_gap1 !== 1'b0) begin
          n_fail++;
          $display("FAIL t6_win k=%0d got tot=%0d min=%0d max=%0d lk=%0b eg=%0b exp 16/1/1/1/0",
                   k, win_total1, win_min1, win_max1, locked1, err_gap1);
        end
      end
      n_run++;
      if (w_obs !== w_exp) begin
        n_fail++;
        $display("FAIL t6_main_model k=%0d got %h exp %h", k, w_obs, w_exp);
      end
    end
    n_run++;
    if (err_gap !== 1'b1 || locked !== 1'b0 || win_total !== 12'd16) begin
      n_fail++;
      $display("FAIL t6_main_flag got eg=%0b lk=%0b tot=%0d exp 1/0/16", err_gap, locked, win_total);
    end
    cen = 1'b0;
    cen1 = 1'b0;
  endtask

  task automatic test_random();
    int unsigned g;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      g = ($urandom_range(0, 9) < 7) ? 7 : $urandom_range(1, 40);
      for (int c = 1; c <= int'(g); c++) begin
        cen = (c == int'(g));
        clr = ($urandom_range(0, 15) == 0);
        tick();
        n_run++;
        if (w_obs !== w_exp) begin
          n_fail++;
          $display("FAIL rand_model cyc=%0d got %h exp %h", tcyc, w_obs, w_exp);
        end
      end
    end
    cen = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", tcyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_bad_gap();
    test_stall();
    test_clr();
    test_reset_mid();
    test_cen_high();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
